// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared types and constants for the 7-segment scan controller
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// rtl/bcd7seg.sv - hex nibble to active-high {a..g,dp} segment pattern, dp always 0
module bcd7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 8'hFC;
      4'h1: seg = 8'h60;
      4'h2: seg = 8'hDA;
      4'h3: seg = 8'hF2;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'hB6;
      4'h6: seg = 8'hBE;
      4'h7: seg = 8'hE0;
      4'h8: seg = 8'hFE;
      4'h9: seg = 8'hF6;
      4'hA: seg = 8'hEE;
      4'hB: seg = 8'h3E;
      4'hC: seg = 8'h9C;
      4'hD: seg = 8'h7A;
      4'hE: seg = 8'h9E;
      4'hF: seg = 8'h8E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scanner with double-buffered, tear-free updates
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              lz_en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4*NDIG-1:0] wr_data,
  input  logic [NDIG-1:0]   wr_dp,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int CW = $clog2(max_int(DIV, BLANK) + 1);
  localparam int IW = $clog2(NDIG);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_done_q, frame_done_d;
  logic [4*NDIG-1:0]   act_data_q, act_data_d;
  logic [NDIG-1:0]     act_dp_q, act_dp_d;
  logic [4*NDIG-1:0]   pend_data_q, pend_data_d;
  logic [NDIG-1:0]     pend_dp_q, pend_dp_d;
  logic                pend_full_q, pend_full_d;
  logic                wr_ready_q, wr_ready_d;

  logic                boundary;
  logic [IW-1:0]       next_idx;
  logic                xfer;
  logic                commit;
  logic [3:0]          nib;
  logic [7:0]          dec_seg;
  logic [7:0]          seg_show;
  logic                blank;
  logic [NDIG:0]       zero_from;

  assign next_idx = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

  // Scan sequencing; boundary marks the cycle that finishes the last digit
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (BLANK > 0) begin
            state_d = ST_GAP;
          end else begin
            idx_d    = next_idx;
            boundary = (idx_q == IDX_LAST);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d    = '0;
          state_d  = ST_SHOW;
          idx_d    = next_idx;
          boundary = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (!en) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      cnt_d    = '0;
      boundary = 1'b0;
    end
  end

  // Double buffer: pending only reaches the active copy between frames or while idle
  always_comb begin
    xfer        = wr_valid & wr_ready_q;
    commit      = pend_full_q & (boundary | (state_q == ST_IDLE));
    act_data_d  = commit ? pend_data_q : act_data_q;
    act_dp_d    = commit ? pend_dp_q : act_dp_q;
    pend_data_d = xfer ? wr_data : pend_data_q;
    pend_dp_d   = xfer ? wr_dp : pend_dp_q;
    pend_full_d = pend_full_q;
    if (commit) begin
      pend_full_d = 1'b0;
    end else if (xfer) begin
      pend_full_d = 1'b1;
    end
    wr_ready_d = ~pend_full_d;
  end

  // zero_from[i]: digit i and every digit above it are zero
  assign zero_from[NDIG] = 1'b1;
  for (genvar g = 0; g < NDIG; g++) begin : g_zero
    assign zero_from[g] = zero_from[g+1] & (act_data_d[4*g +: 4] == 4'h0);
  end

  assign nib = act_data_d[idx_d*4 +: 4];

  bcd7seg u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  // Outputs are computed for the upcoming cycle so they register alongside the state
  always_comb begin
    blank    = lz_en & (idx_d != '0) & zero_from[idx_d];
    seg_show = dec_seg;
    if (blank) begin
      seg_show[SEG_A:SEG_G] = '0;
    end
    seg_show[SEG_DP] = act_dp_d[idx_d];
    if (state_d == ST_SHOW) begin
      an_d  = NDIG'(1) << idx_d;
      seg_d = seg_show;
    end else begin
      an_d  = '0;
      seg_d = SEG_OFF;
    end
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      an_q         <= '0;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      wr_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      wr_ready_q   <= wr_ready_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign wr_ready   = wr_ready_q;

endmodule
